div_result_bcd: RTL and testbench
=================================

Name: div_result_bcd

Overview:
- Downstream consumer of the serial divider's result.
- Detects the divider's completion (rising edge of its done output), captures quotient and remainder, and converts each to sign flag plus packed BCD digits.
- Uses serial double-dabble, one bit per cycle, with both operands converted in parallel.
- Feeds the seven-segment display driver.
- Holds the converted result stable until the next completion.

Parameters:
- width, 6: operand width; must match the divider's width.
- digits, 2: BCD digits per operand; must satisfy 10^digits > 2^width - 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- sign  input  1  1 = q/r are two's complement, 0 = unsigned; sampled at capture.
- div_done  input  1  divider done level; a 0->1 transition means q/r are valid.
- q  input  width  divider quotient.
- r  input  width  divider remainder.
- q_bcd  output  4*digits  quotient magnitude in BCD; digit 0 in bits [3:0].
- r_bcd  output  4*digits  remainder magnitude in BCD.
- q_neg  output  1  quotient negative (sign=1 and q MSB=1).
- r_neg  output  1  remainder negative.
- busy  output  1  conversion in progress.
- valid  output  1  q_bcd/r_bcd/q_neg/r_neg hold a completed conversion.

Behaviour:
- Reset (rst=1 at a clk edge) clears:
  - q_bcd, r_bcd, q_neg, r_neg, busy, valid to 0;
  - state to IDLE, bit counter to 0.
- Reset presets the edge-detect register done_d to 1, so an idle divider (done=1) at reset does not trigger a conversion.
- Reset has priority over all other activity, including mid-conversion; a partially converted result is discarded.
- Edge detect:
  - done_d registers div_done every cycle.
  - A start event is div_done=1 and done_d=0 at the same edge.
- States:
  - IDLE:
    - On a start event, latch operands and move to CONV.
    - If sign=1 and the operand MSB=1: magnitude = two's-complement negation and neg flag = 1.
    - Otherwise: magnitude = operand and neg flag = 0.
    - Clear the internal BCD accumulators and counter; busy=1 from the next cycle.
  - CONV, one operand bit per edge, width edges total:
    - Correct: each accumulator digit >= 5 gets +3 (combinational).
    - Shift the accumulator left 1, shifting in the magnitude MSB; shift the magnitude left 1.
    - Increment the counter. On the edge that processes the last bit (counter = width-1):
      - write the final accumulators to q_bcd/r_bcd;
      - write the latched flags to q_neg/r_neg;
      - set valid=1, busy=0, counter=0, and return to IDLE.
- Latency: outputs update exactly width clk edges after the capture edge; busy is high for exactly width cycles.
- Output stability:
  - Outputs change only at reset or conversion completion.
  - valid stays 1 from first completion until reset; it does not drop during a new conversion.
  - q_neg/r_neg do not change at capture, only at completion.
- Start event while busy:
  - ignored; done_d still tracks div_done;
  - no second conversion is queued.
- Most negative value (sign=1, operand = 1 followed by width-1 zeros):
  - magnitude 2^(width-1) is representable unsigned in width bits;
  - for width=6 the result is 32 with neg=1.
- Zero: magnitude 0, neg=0, all digits 0.
- q and r may change freely outside the capture edge; only capture-edge values matter.

Decomposition:
- Shared include (div_defs.vh):
  - state encodings IDLE=1'b0, CONV=1'b1;
  - helper function for the minimum digit count, used by the bench to check the digits rule.
- Sub-module bcd_dd_step (parameter digits):
  - purely combinational add-3 correction plus 1-bit left shift across all digits;
  - inputs: 4*digits accumulator, 1 shift-in bit; output: next accumulator.
  - Instantiated twice, once for q and once for r.

Test Plan:
- Unsigned: sign=0, q=6'd63, r=6'd0, pulse div_done 0->1.
  - busy=1 for 6 cycles, then q_bcd=8'h63, r_bcd=8'h00, q_neg=r_neg=0, valid=1.
- Signed extreme: sign=1, q=6'b100000, r=6'b111011.
  - q_bcd=8'h32, q_neg=1, r_bcd=8'h05, r_neg=1.
- Same bits unsigned: sign=0, r=6'b111011.
  - r_bcd=8'h59, r_neg=0.
- Overlap: start a conversion; 2 cycles later toggle div_done 0->1 again with q=6'd7.
  - Second event ignored; completion reports the first operands.
  - A later fresh 0->1 converts q=7 to q_bcd=8'h07.
- Reset mid-conversion: assert rst on cycle 3 of CONV.
  - Next cycle all outputs 0, busy=0, valid=0.
  - A held div_done=1 after reset causes no conversion until it falls and rises again.
- Back-to-back: div_done falls and rises on the cycle after completion.
  - New conversion starts; previous outputs and valid=1 stay held until the new result lands width cycles later.

Source files
------------

// File: rtl/div_result_bcd_pkg.sv
// Shared types and helpers for the divider-result BCD converter.
// The state encoding and the digit-count rule live here.
package div_result_bcd_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // Smallest digit count d with 10^d > 2^w - 1.
    function automatic int min_digits(input int w);
        longint lim;
        longint maxv;
        int     d;
        lim  = 1;
        maxv = (longint'(1) << w) - 1;
        d    = 0;
        while (lim <= maxv) begin
            lim = lim * 10;
            d   = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/div_result_bcd_step.sv
// One double-dabble step: add-3 correction on every digit >= 5,
// then shift the whole accumulator left by one bit.
module bcd_dd_step #(
    parameter int digits = 2
) (
    input  logic [4*digits-1:0] i_acc,
    input  logic                i_bit,
    output logic [4*digits-1:0] o_acc
);

    logic [4*digits-1:0] w_corr;

    for (genvar k = 0; k < digits; k++) begin : g_dig
        assign w_corr[4*k +: 4] = (i_acc[4*k +: 4] >= 4'd5) ? i_acc[4*k +: 4] + 4'd3
                                                            : i_acc[4*k +: 4];
    end

    assign o_acc = {w_corr[4*digits-2:0], i_bit};

endmodule

// File: rtl/div_result_bcd.sv
// Captures the divider's quotient/remainder on the rising edge of div_done
// and converts both to sign + BCD serially, one bit per clock.
module div_result_bcd
    import div_result_bcd_pkg::*;
#(
    parameter int width  = 6,
    parameter int digits = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sign,
    input  logic                div_done,
    input  logic [width-1:0]    q,
    input  logic [width-1:0]    r,
    output logic [4*digits-1:0] q_bcd,
    output logic [4*digits-1:0] r_bcd,
    output logic                q_neg,
    output logic                r_neg,
    output logic                busy,
    output logic                valid
);

    localparam int BW = 4 * digits;
    localparam int CW = $clog2(width + 1);
    localparam logic [CW-1:0] LAST = CW'(width - 1);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_done_d;
    logic [width-1:0] r_q_mag, r_r_mag;
    logic [BW-1:0]   r_q_acc, r_r_acc;
    logic            r_q_neg_l, r_r_neg_l;
    logic [BW-1:0]   r_q_bcd, r_r_bcd;
    logic            r_q_neg, r_r_neg, r_busy, r_valid;

    logic            w_start;
    logic            w_q_neg_in, w_r_neg_in;
    logic [width-1:0] w_q_mag_in, w_r_mag_in;
    logic [BW-1:0]   w_q_nxt, w_r_nxt;

    assign w_start    = div_done & ~r_done_d;
    assign w_q_neg_in = sign & q[width-1];
    assign w_r_neg_in = sign & r[width-1];
    // The most negative value negates to itself, which reads correctly as unsigned.
    assign w_q_mag_in = w_q_neg_in ? (~q + 1'b1) : q;
    assign w_r_mag_in = w_r_neg_in ? (~r + 1'b1) : r;

    bcd_dd_step #(.digits(digits)) u_q_step (
        .i_acc (r_q_acc),
        .i_bit (r_q_mag[width-1]),
        .o_acc (w_q_nxt)
    );

    bcd_dd_step #(.digits(digits)) u_r_step (
        .i_acc (r_r_acc),
        .i_bit (r_r_mag[width-1]),
        .o_acc (w_r_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_done_d  <= 1'b1;
            r_q_mag   <= '0;
            r_r_mag   <= '0;
            r_q_acc   <= '0;
            r_r_acc   <= '0;
            r_q_neg_l <= 1'b0;
            r_r_neg_l <= 1'b0;
            r_q_bcd   <= '0;
            r_r_bcd   <= '0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_done_d <= div_done;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_q_mag   <= w_q_mag_in;
                        r_r_mag   <= w_r_mag_in;
                        r_q_neg_l <= w_q_neg_in;
                        r_r_neg_l <= w_r_neg_in;
                        r_q_acc   <= '0;
                        r_r_acc   <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= CONV;
                    end
                end
                CONV: begin
                    r_q_acc <= w_q_nxt;
                    r_r_acc <= w_r_nxt;
                    r_q_mag <= r_q_mag << 1;
                    r_r_mag <= r_r_mag << 1;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_q_bcd <= w_q_nxt;
                        r_r_bcd <= w_r_nxt;
                        r_q_neg <= r_q_neg_l;
                        r_r_neg <= r_r_neg_l;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign q_bcd = r_q_bcd;
    assign r_bcd = r_r_bcd;
    assign q_neg = r_q_neg;
    assign r_neg = r_r_neg;
    assign busy  = r_busy;
    assign valid = r_valid;

endmodule

// File: tb/tb_div_result_bcd.sv
// Directed + randomized bench for div_result_bcd against an arithmetic model
// (magnitude by integer negation, digits by repeated division by ten).
module tb_div_result_bcd;
    import div_result_bcd_pkg::*;

    localparam int W  = 6;
    localparam int D  = 2;
    localparam int BW = 4 * D;

    logic          clk = 1'b0;
    logic          rst;
    logic          sign;
    logic          div_done;
    logic [W-1:0]  q, r;
    logic [BW-1:0] q_bcd, r_bcd;
    logic          q_neg, r_neg, busy, valid;

    int total = 0;
    int bad   = 0;

    logic [BW-1:0] e_q_bcd, e_r_bcd;
    logic          e_q_neg, e_r_neg, e_valid;

    div_result_bcd #(.width(W), .digits(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .sign     (sign),
        .div_done (div_done),
        .q        (q),
        .r        (r),
        .q_bcd    (q_bcd),
        .r_bcd    (r_bcd),
        .q_neg    (q_neg),
        .r_neg    (r_neg),
        .busy     (busy),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Returns {neg, bcd} for one operand.
    function automatic logic [BW:0] model(input logic s, input logic [W-1:0] v);
        int            m;
        logic          n;
        logic [BW-1:0] b;
        n = s && v[W-1];
        m = n ? (1 << W) - int'(v) : int'(v);
        b = '0;
        for (int k = 0; k < D; k++)
            b[4*k +: 4] = 4'((m / (10 ** k)) % 10);
        return {n, b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fresh 0->1 on div_done, then follow the conversion to completion.
    // ovl=1 injects a second 0->1 edge while busy, carrying q=7.
    task automatic convert(input logic s, input logic [W-1:0] qv, input logic [W-1:0] rv,
                           input bit ovl);
        logic [BW:0] mq, mr;
        mq = model(s, qv);
        mr = model(s, rv);
        tick();
        div_done = 1'b0;
        tick();
        div_done = 1'b1;
        sign = s;
        q    = qv;
        r    = rv;
        tick();
        sign = 1'($urandom);
        q    = W'($urandom);
        r    = W'($urandom);
        for (int i = 0; i < W; i++) begin
            chk("busy_conv", 32'(busy), 32'd1);
            chk("hold_q_bcd", 32'(q_bcd), 32'(e_q_bcd));
            chk("hold_r_bcd", 32'(r_bcd), 32'(e_r_bcd));
            chk("hold_neg", 32'({q_neg, r_neg}), 32'({e_q_neg, e_r_neg}));
            chk("hold_valid", 32'(valid), 32'(e_valid));
            if (ovl && i == 1) div_done = 1'b0;
            if (ovl && i == 2) begin
                div_done = 1'b1;
                q = W'(7);
            end
            tick();
        end
        e_q_bcd = mq[BW-1:0];
        e_r_bcd = mr[BW-1:0];
        e_q_neg = mq[BW];
        e_r_neg = mr[BW];
        e_valid = 1'b1;
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_valid", 32'(valid), 32'd1);
        chk("q_bcd", 32'(q_bcd), 32'(e_q_bcd));
        chk("r_bcd", 32'(r_bcd), 32'(e_r_bcd));
        chk("q_neg", 32'(q_neg), 32'(e_q_neg));
        chk("r_neg", 32'(r_neg), 32'(e_r_neg));
    endtask

    initial begin
        if (min_digits(W) > D) begin
            $display("FAIL digits_rule need=%0d have=%0d", min_digits(W), D);
            $fatal(1, "digits");
        end

        rst = 1'b1;
        div_done = 1'b1;
        sign = 1'b0;
        q = '0;
        r = '0;
        tick();
        tick();
        chk("rst_q_bcd", 32'(q_bcd), 32'd0);
        chk("rst_r_bcd", 32'(r_bcd), 32'd0);
        chk("rst_flags", 32'({q_neg, r_neg, busy, valid}), 32'd0);
        e_q_bcd = '0; e_r_bcd = '0; e_q_neg = 0; e_r_neg = 0; e_valid = 0;

        // Idle divider holding done=1 across reset release must not start.
        rst = 1'b0;
        repeat (3) tick();
        chk("held_done_busy", 32'(busy), 32'd0);
        chk("held_done_valid", 32'(valid), 32'd0);

        convert(1'b0, 6'd63, 6'd0, 0);
        chk("ex_q63", 32'(q_bcd), 32'h63);
        convert(1'b1, 6'b100000, 6'b111011, 0);
        chk("ex_q_minneg", 32'({q_neg, q_bcd}), 32'h132);
        chk("ex_r_m5", 32'({r_neg, r_bcd}), 32'h105);
        convert(1'b0, 6'd0, 6'b111011, 0);
        chk("ex_r59", 32'({r_neg, r_bcd}), 32'h059);
        chk("ex_zero", 32'({q_neg, q_bcd}), 32'h000);

        // Overlapping start is dropped, nothing queued behind it.
        convert(1'b0, 6'd41, 6'd18, 1);
        tick();
        chk("ovl_no_queue", 32'(busy), 32'd0);
        convert(1'b0, 6'd7, 6'd3, 0);
        chk("ex_q7", 32'(q_bcd), 32'h07);

        // Reset on the third CONV cycle discards the partial result.
        tick();
        div_done = 1'b0;
        tick();
        div_done = 1'b1;
        sign = 1'b1;
        q = 6'd45;
        r = 6'd12;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_q_bcd", 32'(q_bcd), 32'd0);
        chk("midrst_r_bcd", 32'(r_bcd), 32'd0);
        chk("midrst_flags", 32'({q_neg, r_neg, busy, valid}), 32'd0);
        rst = 1'b0;
        repeat (W + 2) tick();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_valid", 32'(valid), 32'd0);
        e_q_bcd = '0; e_r_bcd = '0; e_q_neg = 0; e_r_neg = 0; e_valid = 0;

        // Back-to-back: each call re-triggers right after the previous completion.
        for (int n = 0; n < 24; n++)
            convert(1'($urandom), W'($urandom), W'($urandom), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
